// File: rtl/oursring_station_gen.sv
// Parametrised oursring ring station: sinks window RD/WR into a local request FIFO,
// forwards everything else, injects local responses. Optional perf counters: OURSRING_STATION_PERF_EN.
module oursring_station_gen #(
    parameter int            AW         = 40,
    parameter int            DW         = 64,
    parameter logic [AW-1:0] BASE_ADDR  = {AW{1'b0}},
    parameter logic [AW-1:0] ADDR_MASK  = {AW{1'b0}},
    parameter int            FIFO_DEPTH = 4,
    parameter int            STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ring_i_valid,
    output logic          ring_i_ready,
    input  logic [1:0]    ring_i_typ,
    input  logic [AW-1:0] ring_i_addr,
    input  logic [DW-1:0] ring_i_data,
    output logic          ring_o_valid,
    input  logic          ring_o_ready,
    output logic [1:0]    ring_o_typ,
    output logic [AW-1:0] ring_o_addr,
    output logic [DW-1:0] ring_o_data,
    output logic          loc_req_valid,
    input  logic          loc_req_ready,
    output logic [1:0]    loc_req_typ,
    output logic [AW-1:0] loc_req_addr,
    output logic [DW-1:0] loc_req_data,
    input  logic          loc_rsp_valid,
    output logic          loc_rsp_ready,
    input  logic [1:0]    loc_rsp_typ,
    input  logic [AW-1:0] loc_rsp_addr,
    input  logic [DW-1:0] loc_rsp_data
`ifdef OURSRING_STATION_PERF_EN
    ,
    output logic [31:0]   perf_fwd_cnt,
    output logic [31:0]   perf_sink_cnt,
    output logic [31:0]   perf_inj_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int FW = 2 + AW + DW;

    // st_type_e: only the sinkable types are needed here
    localparam logic [1:0] ST_RD = 2'd0;
    localparam logic [1:0] ST_WR = 2'd1;

    // st_state_e
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_DR_OUT       = 2'd1;
    localparam logic [1:0] ST_INDIRECT_IN  = 2'd2;
    localparam logic [1:0] ST_INDIRECT_OUT = 2'd3;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SW'(STARVE_MAX)) ? v : v + SW'(1);
    endfunction

    logic [1:0]    state;
    logic [1:0]    out_typ_p0;
    logic [AW-1:0] out_addr_p0;
    logic [DW-1:0] out_data_p0;
    logic [SW-1:0] starve_cnt;

    logic [FW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    logic match, sink, out_idle, out_free, fwd_req, inj_grant;
    logic fifo_empty, fifo_full, push, pop, fwd_xfer;

    assign match      = (ring_i_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    assign sink       = match && ((ring_i_typ == ST_RD) || (ring_i_typ == ST_WR));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // ST_INDIRECT_IN is never loaded; treat it as empty if it ever appears
    assign out_idle  = (state == ST_IDLE) || (state == ST_INDIRECT_IN);
    assign out_free  = out_idle || ring_o_ready;
    assign fwd_req   = ring_i_valid && !sink;
    assign inj_grant = rstn && out_free && loc_rsp_valid
                       && (!fwd_req || (starve_cnt == SW'(STARVE_MAX)));

    assign ring_i_ready  = rstn && (sink ? !fifo_full : (out_free && !inj_grant));
    assign loc_rsp_ready = inj_grant;

    assign push     = ring_i_valid && ring_i_ready && sink;
    assign fwd_xfer = ring_i_valid && ring_i_ready && !sink;
    assign pop      = !fifo_empty && loc_req_ready;

    assign loc_req_valid = !fifo_empty;
    assign {loc_req_typ, loc_req_addr, loc_req_data} = fifo_mem[rd_ptr[PW-1:0]];

    assign ring_o_valid = !out_idle;
    assign ring_o_typ   = out_typ_p0;
    assign ring_o_addr  = out_addr_p0;
    assign ring_o_data  = out_data_p0;

    // request FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= {ring_i_typ, ring_i_addr, ring_i_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // output register stage p0
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else if (fwd_xfer) begin
            state <= ST_DR_OUT;
        end else if (inj_grant) begin
            state <= ST_INDIRECT_OUT;
        end else if (ring_o_ready) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (fwd_xfer) begin
            out_typ_p0  <= ring_i_typ;
            out_addr_p0 <= ring_i_addr;
            out_data_p0 <= ring_i_data;
        end else if (inj_grant) begin
            out_typ_p0  <= loc_rsp_typ;
            out_addr_p0 <= loc_rsp_addr;
            out_data_p0 <= loc_rsp_data;
        end
    end

    // consecutive losses of a waiting injection to forwarded traffic
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (inj_grant) begin
            starve_cnt <= '0;
        end else if (loc_rsp_valid && fwd_xfer) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

`ifdef OURSRING_STATION_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fwd_cnt  <= '0;
            perf_sink_cnt <= '0;
            perf_inj_cnt  <= '0;
        end else begin
            if (fwd_xfer)  perf_fwd_cnt  <= perf_fwd_cnt + 32'd1;
            if (push)      perf_sink_cnt <= perf_sink_cnt + 32'd1;
            if (inj_grant) perf_inj_cnt  <= perf_inj_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oursring_station_gen.sv
// Self-checking bench for oursring_station_gen: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_oursring_station_gen;

    localparam int            AW   = 40;
    localparam int            DW   = 64;
    localparam logic [AW-1:0] BASE = 40'h10_0000_0000;
    localparam logic [AW-1:0] MASK = 40'hFF_0000_0000;
    localparam int            DEPTH = 4;
    localparam int            SMAX  = 8;

    localparam logic [1:0] ST_RD  = 2'd0;
    localparam logic [1:0] ST_WR  = 2'd1;
    localparam logic [1:0] ST_RSP = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ring_i_valid, ring_i_ready;
    logic [1:0]    ring_i_typ;
    logic [AW-1:0] ring_i_addr;
    logic [DW-1:0] ring_i_data;
    logic          ring_o_valid, ring_o_ready;
    logic [1:0]    ring_o_typ;
    logic [AW-1:0] ring_o_addr;
    logic [DW-1:0] ring_o_data;
    logic          loc_req_valid, loc_req_ready;
    logic [1:0]    loc_req_typ;
    logic [AW-1:0] loc_req_addr;
    logic [DW-1:0] loc_req_data;
    logic          loc_rsp_valid, loc_rsp_ready;
    logic [1:0]    loc_rsp_typ;
    logic [AW-1:0] loc_rsp_addr;
    logic [DW-1:0] loc_rsp_data;

    always #5 clk = ~clk;

    oursring_station_gen #(
        .AW(AW), .DW(DW), .BASE_ADDR(BASE), .ADDR_MASK(MASK),
        .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ring_i_valid(ring_i_valid), .ring_i_ready(ring_i_ready),
        .ring_i_typ(ring_i_typ), .ring_i_addr(ring_i_addr), .ring_i_data(ring_i_data),
        .ring_o_valid(ring_o_valid), .ring_o_ready(ring_o_ready),
        .ring_o_typ(ring_o_typ), .ring_o_addr(ring_o_addr), .ring_o_data(ring_o_data),
        .loc_req_valid(loc_req_valid), .loc_req_ready(loc_req_ready),
        .loc_req_typ(loc_req_typ), .loc_req_addr(loc_req_addr), .loc_req_data(loc_req_data),
        .loc_rsp_valid(loc_rsp_valid), .loc_rsp_ready(loc_rsp_ready),
        .loc_rsp_typ(loc_rsp_typ), .loc_rsp_addr(loc_rsp_addr), .loc_rsp_data(loc_rsp_data)
    );

    typedef struct {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pkt_t;

    typedef struct {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            exp_sink;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // reference model state
    pkt_t m_q[$];
    bit   m_out_v;
    pkt_t m_out;
    int   m_starve;

    vec_t vt[6];
    pkt_t head;
    bit   hold_i, hold_r;

    initial begin
        vt[0] = '{ST_RD,  40'h10_0000_0040, 64'h0000_0000_0000_0001, 1'b1};
        vt[1] = '{ST_WR,  40'h20_0000_0000, 64'h0000_0000_DEAD_BEEF, 1'b0};
        vt[2] = '{ST_RSP, 40'h10_0000_0000, 64'h0000_0000_0000_0002, 1'b0};
        vt[3] = '{ST_WR,  40'h10_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b1};
        vt[4] = '{ST_ERR, 40'h10_0000_1234, 64'h0000_0000_0000_0003, 1'b0};
        vt[5] = '{ST_RD,  40'h11_0000_0000, 64'h0000_0000_0000_0004, 1'b0};

        // reset with inputs active
        rstn = 1'b0;
        ring_i_valid = 1'b1; ring_i_typ = ST_WR; ring_i_addr = 40'h20_0000_0000; ring_i_data = '0;
        ring_o_ready = 1'b1; loc_req_ready = 1'b0;
        loc_rsp_valid = 1'b1; loc_rsp_typ = ST_RSP; loc_rsp_addr = '0; loc_rsp_data = '0;
        repeat (3) tick();
        sample();
        chk("rst_ring_o_valid", ring_o_valid, 0);
        chk("rst_loc_req_valid", loc_req_valid, 0);
        chk("rst_ring_i_ready", ring_i_ready, 0);
        chk("rst_loc_rsp_ready", loc_rsp_ready, 0);
        tick();
        rstn = 1'b1; ring_i_valid = 1'b0; loc_rsp_valid = 1'b0;
        tick();

        // vector table: classification and 1-cycle latency
        loc_req_ready = 1'b1; ring_o_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ring_i_valid = 1'b1; ring_i_typ = vt[i].typ;
            ring_i_addr = vt[i].addr; ring_i_data = vt[i].data;
            sample();
            chk($sformatf("vec%0d_ring_i_ready", i), ring_i_ready, 1);
            tick();
            ring_i_valid = 1'b0;
            sample();
            chk($sformatf("vec%0d_loc_req_valid", i), loc_req_valid, vt[i].exp_sink);
            chk($sformatf("vec%0d_ring_o_valid", i), ring_o_valid, !vt[i].exp_sink);
            if (vt[i].exp_sink) begin
                chk($sformatf("vec%0d_req_fields", i), {loc_req_typ, loc_req_addr, loc_req_data},
                    {vt[i].typ, vt[i].addr, vt[i].data});
            end else begin
                chk($sformatf("vec%0d_out_fields", i), {ring_o_typ, ring_o_addr, ring_o_data},
                    {vt[i].typ, vt[i].addr, vt[i].data});
            end
            tick();
        end

        // FIFO full backpressure and ordering
        loc_req_ready = 1'b0;
        ring_i_typ = ST_RD; ring_i_data = 64'h55;
        for (int i = 0; i < 4; i++) begin
            ring_i_valid = 1'b1; ring_i_addr = BASE + AW'(i);
            sample();
            chk($sformatf("fill%0d_ready", i), ring_i_ready, 1);
            tick();
        end
        ring_i_addr = BASE + AW'(4);
        sample();
        chk("full_ready", ring_i_ready, 0);
        tick();
        loc_req_ready = 1'b1;
        sample();
        chk("full_pop_ready", ring_i_ready, 0);
        chk("full_head_addr", loc_req_addr, BASE);
        tick();
        loc_req_ready = 1'b0;
        sample();
        chk("after_pop_ready", ring_i_ready, 1);
        tick();
        ring_i_valid = 1'b0; loc_req_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample();
            chk($sformatf("pop%0d_valid", k), loc_req_valid, 1);
            chk($sformatf("pop%0d_addr", k), loc_req_addr, BASE + AW'(k));
            tick();
        end
        sample();
        chk("fifo_drained", loc_req_valid, 0);
        tick();

        // starvation-bounded injection
        ring_o_ready = 1'b1;
        ring_i_valid = 1'b1; ring_i_typ = ST_WR; ring_i_addr = 40'h20_0000_1000; ring_i_data = 64'h77;
        loc_rsp_valid = 1'b1; loc_rsp_typ = ST_RSP; loc_rsp_addr = 40'h30_0000_0000; loc_rsp_data = 64'h99;
        for (int c = 0; c < 27; c++) begin
            sample();
            chk($sformatf("starve%0d_rsp_ready", c), loc_rsp_ready, (c % 9) == 8);
            chk($sformatf("starve%0d_ring_i_ready", c), ring_i_ready, (c % 9) != 8);
            if (c > 0) begin
                chk($sformatf("starve%0d_out_addr", c), ring_o_addr,
                    ((c - 1) % 9 == 8) ? 40'h30_0000_0000 : 40'h20_0000_1000);
            end
            tick();
        end

        // stalled output holds; reset mid-operation discards everything
        loc_rsp_valid = 1'b0; loc_req_ready = 1'b0;
        ring_i_typ = ST_RD; ring_i_addr = 40'h10_0000_0777;
        tick();
        ring_i_typ = ST_WR; ring_i_addr = 40'h20_0000_0AAA; ring_i_data = 64'h1111;
        tick();
        ring_o_ready = 1'b0; ring_i_addr = 40'h20_0000_0BBB; ring_i_data = 64'h2222;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("stall%0d_valid", c), ring_o_valid, 1);
            chk($sformatf("stall%0d_fields", c), {ring_o_addr, ring_o_data}, {40'h20_0000_0AAA, 64'h1111});
            chk($sformatf("stall%0d_ring_i_ready", c), ring_i_ready, 0);
            chk($sformatf("stall%0d_loc_req_valid", c), loc_req_valid, 1);
            tick();
        end
        rstn = 1'b0; loc_rsp_valid = 1'b1;
        sample();
        chk("midrst_ring_i_ready", ring_i_ready, 0);
        chk("midrst_loc_rsp_ready", loc_rsp_ready, 0);
        tick();
        rstn = 1'b1; ring_i_valid = 1'b0; loc_rsp_valid = 1'b0;
        sample();
        chk("midrst_ring_o_valid", ring_o_valid, 0);
        chk("midrst_loc_req_valid", loc_req_valid, 0);
        tick();

        // randomized traffic against the reference model
        m_q.delete(); m_out_v = 0; m_starve = 0;
        hold_i = 0; hold_r = 0;
        for (int c = 0; c < 600; c++) begin
            bit sink, full, free, freq, inj, iready, push, fwd, pop;
            if (!hold_i) begin
                ring_i_valid = $urandom_range(0, 1) == 1;
                ring_i_typ   = 2'($urandom);
                ring_i_addr  = ($urandom_range(0, 1) == 1) ? {8'h10, 32'($urandom)} : {8'($urandom), 32'($urandom)};
                ring_i_data  = {32'($urandom), 32'($urandom)};
            end
            if (!hold_r) begin
                loc_rsp_valid = $urandom_range(0, 2) == 0;
                loc_rsp_typ   = 2'($urandom);
                loc_rsp_addr  = {8'($urandom), 32'($urandom)};
                loc_rsp_data  = {32'($urandom), 32'($urandom)};
            end
            ring_o_ready  = $urandom_range(0, 3) != 0;
            loc_req_ready = $urandom_range(0, 1) == 1;

            sink   = ((ring_i_addr & MASK) == (BASE & MASK)) && (ring_i_typ == ST_RD || ring_i_typ == ST_WR);
            full   = m_q.size() == DEPTH;
            free   = !m_out_v || ring_o_ready;
            freq   = ring_i_valid && !sink;
            inj    = free && loc_rsp_valid && (!freq || m_starve == SMAX);
            iready = sink ? !full : (free && !inj);

            sample();
            chk("rnd_ring_i_ready", ring_i_ready, iready);
            chk("rnd_loc_rsp_ready", loc_rsp_ready, inj);
            chk("rnd_ring_o_valid", ring_o_valid, m_out_v);
            if (m_out_v)
                chk("rnd_ring_o_fields", {ring_o_typ, ring_o_addr, ring_o_data},
                    {m_out.typ, m_out.addr, m_out.data});
            chk("rnd_loc_req_valid", loc_req_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                head = m_q[0];
                chk("rnd_loc_req_fields", {loc_req_typ, loc_req_addr, loc_req_data},
                    {head.typ, head.addr, head.data});
            end

            push = ring_i_valid && iready && sink;
            fwd  = ring_i_valid && iready && !sink;
            pop  = (m_q.size() != 0) && loc_req_ready;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{ring_i_typ, ring_i_addr, ring_i_data});
            if (inj) m_starve = 0;
            else if (loc_rsp_valid && fwd && m_starve < SMAX) m_starve++;
            if (fwd) begin
                m_out_v = 1; m_out = '{ring_i_typ, ring_i_addr, ring_i_data};
            end else if (inj) begin
                m_out_v = 1; m_out = '{loc_rsp_typ, loc_rsp_addr, loc_rsp_data};
            end else if (ring_o_ready) begin
                m_out_v = 0;
            end
            hold_i = ring_i_valid && !iready;
            hold_r = loc_rsp_valid && !inj;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oursring_station_gen.md
Name: oursring_station_gen

Overview:
- Parametrised ring station for the oursring fabric; the next generation of the fixed 40-bit-address / 64-bit-data station.
- Sits between an upstream and a downstream ring link, and serves one local slave.
- Sinks RD/WR packets addressed to its window into a local request FIFO, and forwards all other packets.
- Injects local responses onto the ring, using starvation-bounded arbitration against forwarded traffic.

Parameters:
- AW, 40: address width of ring and local packets.
- DW, 64: data width.
- BASE_ADDR, {AW{1'b0}}: station window base.
- ADDR_MASK, {AW{1'b0}}: bits compared for a window match; all-zero matches every address.
- FIFO_DEPTH, 4: local request FIFO entries; power of two, ≥2.
- STARVE_MAX, 8: maximum consecutive losses of a pending injection before it is forced; ≥1.

Ports:
- clk in 1: clock.
- rstn in 1: synchronous active-low reset.
- ring_i_valid in 1: upstream packet valid.
- ring_i_ready out 1: upstream accept.
- ring_i_typ in 2: st_type_e.
- ring_i_addr in AW.
- ring_i_data in DW.
- ring_o_valid out 1: downstream packet valid.
- ring_o_ready in 1: downstream accept.
- ring_o_typ out 2.
- ring_o_addr out AW.
- ring_o_data out DW.
- loc_req_valid out 1: request to local slave.
- loc_req_ready in 1.
- loc_req_typ out 2.
- loc_req_addr out AW.
- loc_req_data out DW.
- loc_rsp_valid in 1: local response for injection.
- loc_rsp_ready out 1.
- loc_rsp_typ in 2.
- loc_rsp_addr in AW.
- loc_rsp_data in DW.

Behaviour:
- One clock, clk; rstn is synchronous and active-low. All state updates on the rising edge.
- Handshake: a transfer occurs when valid && ready.
  - A valid output holds typ/addr/data stable until the transfer.
  - A valid output never drops before the transfer.
- Classification: match = (ring_i_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
  - sink = match && typ ∈ {ST_RD, ST_WR}.
  - ST_RSP and ST_ERR are always forwarded, regardless of address.
- Sink path:
  - ring_i_ready = !fifo_full. The pop in the same cycle is not considered.
  - Push on transfer; loc_req_valid = !fifo_empty, driven from the FIFO head.
  - Accept-to-loc_req_valid latency is 1 cycle.
  - Simultaneous push and pop when not full or empty: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output register: single-entry register, state encoded with st_state_e.
  - ST_IDLE: empty.
  - ST_DR_OUT: holds a forwarded packet.
  - ST_INDIRECT_OUT: holds an injected local packet.
  - ST_INDIRECT_IN: unused; it decodes as ST_IDLE.
  - out_free = (state == ST_IDLE) || ring_o_ready.
  - ring_o_valid = (state != ST_IDLE).
- Arbitration, evaluated each cycle:
  - fwd_req = ring_i_valid && !sink.
  - inj_grant = out_free && loc_rsp_valid && (!fwd_req || starve_cnt == STARVE_MAX).
  - Forward path: ring_i_ready = out_free && !inj_grant.
  - loc_rsp_ready = inj_grant.
  - Loads: a forward transfer sets state to ST_DR_OUT; an injection sets state to ST_INDIRECT_OUT.
  - If nothing loads and ring_o_ready is high, state goes to ST_IDLE.
  - Forward latency: 1 cycle from ring_i transfer to ring_o_valid. Back-to-back throughput is 1 packet/cycle while ring_o_ready is held high.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments, saturating, when loc_rsp_valid && out_free && the forward path wins.
  - Clears on inj_grant.
  - Holds otherwise.
- Injected packets pass unmodified. They are never re-classified by this station.
- Reset values:
  - ring_o_valid = 0; state = ST_IDLE.
  - FIFO empty; loc_req_valid = 0.
  - ring_i_ready: combinational, 0 while rstn is low.
  - loc_rsp_ready = 0 while rstn is low.
  - starve_cnt = 0.
  - Data outputs are don't-care.
- Reset mid-operation: all buffered packets are discarded, with no handshake. No partial packet is emitted after reset.

Optional Feature:
- Macro: OURSRING_STATION_PERF_EN.
- When defined, adds three output ports: perf_fwd_cnt, perf_sink_cnt and perf_inj_cnt, each out 32.
  - They count forward, sink and inject transfers respectively.
  - They wrap at 2^32 and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- BASE_ADDR=40'h10_0000_0000, ADDR_MASK=40'hFF_0000_0000; send ST_RD at addr 40'h10_0000_0040 → loc_req_valid next cycle with the same addr; ring_o_valid stays 0.
- Send ST_WR at addr 40'h20_0000_0000, data 64'hDEAD_BEEF, with ring_o_ready=1 → ring_o_valid 1 cycle later with identical fields.
- Send ST_RSP at a matching address → forwarded, not sunk.
- loc_req_ready=0; send 5 matching RDs (FIFO_DEPTH=4) → 4 accepted, ring_i_ready=0 on the 5th; one pop → 5th accepted the next cycle; pop order is FIFO.
- Continuous forward traffic plus loc_rsp_valid held 1 (STARVE_MAX=8) → injection granted on the 9th arbitration cycle, starve_cnt returns to 0, pattern repeats every 9 cycles.
- ring_o_ready=0 with the output register full → ring_i_ready=0 for non-sink packets, contents held stable; assert rstn=0 for one cycle → ring_o_valid=0 and FIFO empty on the next edge.
